mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the processor's single unified memory port between two requesters: the multicycle control state machine's fetch/load/store path (cpu) and the external program loader/debug port (ext). Each requester gets a req/ack handshake. The arbiter sequences each memory access through issue, latency wait and acknowledge, and stalls the CPU control FSM via cpu_wait. It sits between the control/datapath and the memory block.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
MEM_LAT, 1, memory read latency in cycles from the mem_en sample edge to valid mem_rdata; legal range is 1 to 7
RR_EN, 1, 1 = round-robin on contention; 0 = fixed cpu priority

Ports:
CLK  in  1  single system clock; all state on rising edge
Reset  in  1  asynchronous, active-low reset
cpu_req  in  1  cpu access request; held until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  cpu address
cpu_wdata  in  DATA_W  cpu write data
cpu_rdata  out  DATA_W  read data; valid when cpu_ack = 1
cpu_ack  out  1  one-cycle completion pulse
cpu_wait  out  1  combinational stall = cpu_req & ~cpu_ack
ext_req, ext_we, ext_addr, ext_wdata  in  1/1/ADDR_W/DATA_W  ext request group, same rules as cpu
ext_rdata  out  DATA_W  ext read data
ext_ack  out  1  one-cycle completion pulse
ext_hold  in  1  1 = cpu requests are never granted (loader owns memory)
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
grant_ext  out  1  1 while the current or last access belongs to ext (debug)

Behaviour:
- Reset = 0, asynchronous: state goes to IDLE. All outputs are 0. last_grant = ext, so the cpu wins the first tie. The latency counter is cleared.
- FSM states, 2-bit: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - Eligible requests are ext_req and (cpu_req & ~ext_hold).
  - If none is eligible, stay in IDLE.
  - If one is eligible, grant it.
  - If both are eligible and RR_EN = 1, grant the requester that is not last_grant.
  - If both are eligible and RR_EN = 0, grant cpu.
  - On the grant edge, latch the winner's addr/wdata/we into mem_addr/mem_wdata/mem_we registers, update last_grant and grant_ext, and go to ISSUE.
- ISSUE (exactly 1 cycle): mem_en = 1 and mem_we = latched we. Load counter = MEM_LAT, then go to WAIT.
- WAIT (MEM_LAT cycles): mem_en = 0 and mem_we = 0. Decrement the counter each cycle. On the edge where the counter reaches 1:
  - for a read, capture mem_rdata into the granted requester's rdata register;
  - for a write, leave rdata unchanged;
  - go to ACK.
- ACK (1 cycle): the granted requester's ack = 1. Next state is IDLE.
  - The requester must drop or renew req on the edge that ends ACK.
  - A req still high in the following IDLE cycle is treated as a new access.
- Latency: req sampled in IDLE at edge 0 gives ack high during cycle MEM_LAT+2. With MEM_LAT = 1, ack is in cycle 3. Back-to-back accesses from one requester take MEM_LAT+3 cycles each.
- The non-granted rdata register and ack hold 0 / their previous value; rdata registers only change on read completion.
- Requester inputs that change after the grant edge are ignored, since the access uses latched values.
- A req dropped mid-access does not abort: the access completes and ack still pulses.
- ext_hold rising mid cpu access does not abort it. ext_hold only gates new cpu grants in IDLE.
- Reset asserted during ISSUE before its terminating edge forces mem_en = 0 immediately, so no write occurs. Reset during WAIT or ACK discards data, and no ack is issued.
- Address wrap: no arithmetic on addresses; they pass through unchanged.

Decomposition:
- Shared definitions include mem_arb_defs.vh holds:
  - state encodings IDLE = 2'b00, ISSUE = 2'b01, WAIT = 2'b10, ACK = 2'b11;
  - requester IDs REQ_CPU = 1'b0, REQ_EXT = 1'b1;
  - counter width constant LAT_W = 3.
- One sub-module, arb_pick2: combinational 2-way picker. Inputs are two eligible bits, last_grant and RR_EN. Outputs are grant_valid and grant_id. The FSM, latches and counter stay in the top module.

Test Plan:
- Reset = 0 while both reqs are high: all outputs 0, no mem_en. Release Reset: cpu is granted first and mem_en pulses in cycle 1.
- cpu read 0x0010 with memory holding 0xBEEF, MEM_LAT = 1: mem_en = 1, mem_addr = 0x0010, mem_we = 0 in cycle 1. cpu_ack = 1 with cpu_rdata = 0xBEEF in cycle 3. cpu_wait = 1 in cycles 0-2.
- cpu and ext both request continuously, RR_EN = 1: grants alternate cpu, ext, cpu, ext with each ack MEM_LAT+3 cycles apart. With RR_EN = 0, cpu is always served and ext waits until cpu_req drops.
- ext_hold = 1 with cpu_req high, then ext writes 0x1234 to 0x0020: the cpu is never granted, mem_we = 1 and mem_wdata = 0x1234 in ISSUE, and ext_ack is in cycle 3. Drop ext_hold: the cpu is granted next IDLE, and reading 0x0020 returns 0x1234.
- Reset pulsed low during the ISSUE cycle of a write of 0x5555 to 0x0030: mem_en drops immediately, memory[0x0030] is unchanged, and no ack is issued.
- MEM_LAT = 3 read of 0x0040 holding 0xA5A5: ack is in cycle 5 with rdata = 0xA5A5. mem_rdata is ignored before the capture edge.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter: FSM encoding,
// requester IDs and latency counter width.
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    ACK   = 2'b11
  } arb_state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_EXT = 1'b1;
  localparam int   LAT_W   = 3;
endpackage

// File: rtl/mem_port_arbiter_arb_pick2.sv
// Combinational two-way picker: round-robin against last_grant or fixed cpu
// priority when both requesters are eligible.
module arb_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic elig_cpu,
  input  logic elig_ext,
  input  logic last_grant,
  input  logic rr_en,
  output logic grant_valid,
  output logic grant_id
);
  always_comb begin
    grant_valid = elig_cpu | elig_ext;
    grant_id    = REQ_CPU;
    if (elig_cpu && elig_ext) grant_id = rr_en ? ~last_grant : REQ_CPU;
    else if (elig_ext)        grant_id = REQ_EXT;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the cpu control path and the ext loader,
// sequencing each access through issue, latency wait and acknowledge.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1,
  parameter bit RR_EN   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_wait,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_ack,
  input  logic              ext_hold,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              grant_ext
);
  arb_state_t       state, nxt;
  logic [LAT_W-1:0] cnt;
  logic             last_grant, we_q, grant_valid, grant_id;

  arb_pick2 u_pick (
    .elig_cpu    (cpu_req & ~ext_hold),
    .elig_ext    (ext_req),
    .last_grant  (last_grant),
    .rr_en       (RR_EN),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= nxt;

  // Strobes decode straight from state so an async reset kills them at once.
  always_comb begin
    nxt      = state;
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    cpu_ack  = 1'b0;
    ext_ack  = 1'b0;
    case (state)
      IDLE:  if (grant_valid) nxt = ISSUE;
      ISSUE: begin
        nxt    = WAIT;
        mem_en = 1'b1;
        mem_we = we_q;
      end
      WAIT:  if (cnt == LAT_W'(1)) nxt = ACK;
      ACK: begin
        nxt     = IDLE;
        cpu_ack = (grant_ext == REQ_CPU);
        ext_ack = (grant_ext == REQ_EXT);
      end
      default: nxt = IDLE;
    endcase
    cpu_wait = rst_n & cpu_req & ~cpu_ack;
  end

  // grant_ext doubles as the owner of the in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      last_grant <= REQ_EXT;
      grant_ext  <= 1'b0;
      we_q       <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rdata  <= '0;
      ext_rdata  <= '0;
    end else begin
      case (state)
        IDLE: if (grant_valid) begin
          last_grant <= grant_id;
          grant_ext  <= grant_id;
          we_q       <= grant_id ? ext_we    : cpu_we;
          mem_addr   <= grant_id ? ext_addr  : cpu_addr;
          mem_wdata  <= grant_id ? ext_wdata : cpu_wdata;
        end
        ISSUE: cnt <= LAT_W'(MEM_LAT);
        WAIT: begin
          cnt <= cnt - LAT_W'(1);
          if (cnt == LAT_W'(1) && !we_q) begin
            if (grant_ext == REQ_EXT) ext_rdata <= mem_rdata;
            else                      cpu_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT=1 round-robin, MEM_LAT=3
// fixed priority) checked every cycle against an access-phase reference model.
module tb_mem_port_arbiter;
  localparam int N = 2;

  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b1;
  logic cpu_req[N], cpu_we[N], ext_req[N], ext_we[N], ext_hold[N];
  logic [15:0] cpu_addr[N], cpu_wdata[N], ext_addr[N], ext_wdata[N];
  logic [15:0] cpu_rdata[N], ext_rdata[N], mem_addr[N], mem_wdata[N], mem_rdata[N];
  logic cpu_ack[N], cpu_wait[N], ext_ack[N], mem_en[N], mem_we[N], grant_ext[N];
  int checks = 0, failures = 0, cyc = 0;

  always #5 clk = ~clk;

  function automatic int lat(int g); return (g == 0) ? 1 : 3; endfunction
  function automatic bit rr(int g);  return (g == 0);         endfunction

  for (genvar g = 0; g < N; g++) begin : inst
    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(g == 0 ? 1 : 3),
                       .RR_EN(g == 0)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]),
      .cpu_wdata(cpu_wdata[g]), .cpu_rdata(cpu_rdata[g]), .cpu_ack(cpu_ack[g]),
      .cpu_wait(cpu_wait[g]),
      .ext_req(ext_req[g]), .ext_we(ext_we[g]), .ext_addr(ext_addr[g]),
      .ext_wdata(ext_wdata[g]), .ext_rdata(ext_rdata[g]), .ext_ack(ext_ack[g]),
      .ext_hold(ext_hold[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .grant_ext(grant_ext[g]));

    // Memory block: read data is valid only in the cycle before the
    // MEM_LAT-th edge after the mem_en sample edge; junk otherwise.
    logic [15:0] pmem [256];
    logic [7:0]  rda;
    logic [15:0] junk;
    int          d;
    always @(posedge clk) begin
      junk <= 16'($urandom);
      if (clr) begin
        for (int i = 0; i < 256; i++) pmem[i] <= '0;
        d <= 0;
      end else if (mem_en[g]) begin
        if (mem_we[g]) pmem[mem_addr[g][7:0]] <= mem_wdata[g];
        else begin rda <= mem_addr[g][7:0]; d <= lat(g); end
      end else if (d > 0) d <= d - 1;
    end
    assign mem_rdata[g] = (d == 1) ? pmem[rda] : junk;
  end

  // Reference model: each access is a phase count 1..LAT+2 after the grant
  // (1 = strobe, LAT+2 = acknowledge); 0 = free.
  int ph[N];
  bit own[N], we_l[N], last[N], gext[N], ec, ee;
  logic [15:0] addr_l[N], wdata_l[N], rd[N][2];
  logic [15:0] mmem[N][256];

  always @(posedge clk or negedge rst_n) begin
    for (int g = 0; g < N; g++) begin
      if (clr) for (int i = 0; i < 256; i++) mmem[g][i] = '0;
      if (!rst_n) begin
        ph[g] = 0; last[g] = 1'b1; gext[g] = 1'b0; we_l[g] = 1'b0;
        addr_l[g] = '0; wdata_l[g] = '0; rd[g][0] = '0; rd[g][1] = '0;
      end else if (ph[g] == 0) begin
        ec = cpu_req[g] && !ext_hold[g];
        ee = ext_req[g];
        if (ec || ee) begin
          own[g]     = (ec && ee) ? (rr(g) ? !last[g] : 1'b0) : ee;
          we_l[g]    = own[g] ? ext_we[g]    : cpu_we[g];
          addr_l[g]  = own[g] ? ext_addr[g]  : cpu_addr[g];
          wdata_l[g] = own[g] ? ext_wdata[g] : cpu_wdata[g];
          last[g] = own[g]; gext[g] = own[g]; ph[g] = 1;
        end
      end else if (ph[g] == 1) begin
        if (we_l[g]) mmem[g][addr_l[g][7:0]] = wdata_l[g];
        ph[g] = 2;
      end else if (ph[g] == lat(g) + 1) begin
        if (!we_l[g]) rd[g][own[g]] = mmem[g][addr_l[g][7:0]];
        ph[g] = ph[g] + 1;
      end else if (ph[g] == lat(g) + 2) ph[g] = 0;
      else ph[g] = ph[g] + 1;
    end
  end

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [69:0] o, e;
    bit ack_c, ack_e;
    for (int g = 0; g < N; g++) begin
      ack_c = (ph[g] == lat(g) + 2) && !own[g];
      ack_e = (ph[g] == lat(g) + 2) && own[g];
      e = {ph[g] == 1, (ph[g] == 1) && we_l[g], ack_c, ack_e,
           rst_n && cpu_req[g] && !ack_c, gext[g], addr_l[g], wdata_l[g],
           rd[g][0], rd[g][1]};
      o = {mem_en[g], mem_we[g], cpu_ack[g], ext_ack[g], cpu_wait[g], grant_ext[g],
           mem_addr[g], mem_wdata[g], cpu_rdata[g], ext_rdata[g]};
      chk($sformatf("model inst%0d cyc%0d", g, cyc), o, e);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    check_all();
  endtask

  // One access on both instances; checks ack cycle (LAT+2) and read data.
  task automatic xfer(input bit who, input bit we, input logic [15:0] a,
                      input logic [15:0] wd, input bit hold);
    bit pend[N];
    for (int g = 0; g < N; g++) begin
      cpu_req[g] = !who || hold; ext_req[g] = who; ext_hold[g] = hold;
      if (!who) begin cpu_we[g] = we; cpu_addr[g] = a; cpu_wdata[g] = wd; end
      else      begin ext_we[g] = we; ext_addr[g] = a; ext_wdata[g] = wd; end
      pend[g] = 1'b1;
    end
    for (int t = 1; t <= 20 && (pend[0] || pend[1]); t++) begin
      step();
      for (int g = 0; g < N; g++)
        if (pend[g] && (who ? ext_ack[g] : cpu_ack[g])) begin
          pend[g] = 1'b0;
          if (who) ext_req[g] = 1'b0; else cpu_req[g] = 1'b0;
          chk($sformatf("ack_cycle inst%0d a=%h", g, a), 70'(t), 70'(lat(g) + 2));
          if (!we) chk($sformatf("rdata inst%0d a=%h", g, a),
                       70'(who ? ext_rdata[g] : cpu_rdata[g]), 70'(wd));
        end
    end
    for (int g = 0; g < N; g++) chk($sformatf("ack_timeout inst%0d", g), 70'(pend[g]), 70'(0));
    step();
  endtask

  int nc[N], ne[N];

  initial begin
    for (int g = 0; g < N; g++) begin
      cpu_req[g] = 1'b1; ext_req[g] = 1'b1; cpu_we[g] = 1'b0; ext_we[g] = 1'b0;
      cpu_addr[g] = '0; ext_addr[g] = '0; cpu_wdata[g] = '0; ext_wdata[g] = '0;
      ext_hold[g] = 1'b0;
    end
    // Reset held with both requests up: everything quiet.
    step(); step();
    clr = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int g = 0; g < N; g++)
      chk($sformatf("first_grant inst%0d", g), {68'd0, mem_en[g], grant_ext[g]}, 70'b10);
    for (int g = 0; g < N; g++) begin cpu_req[g] = 1'b0; ext_req[g] = 1'b0; end
    repeat (8) step();

    xfer(1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
    xfer(1'b1, 1'b1, 16'h0040, 16'hA5A5, 1'b0);
    xfer(1'b0, 1'b0, 16'h0010, 16'hBEEF, 1'b0);
    xfer(1'b0, 1'b0, 16'h0040, 16'hA5A5, 1'b0);
    // Loader owns memory: cpu stays pending, then reads the loader's write.
    for (int g = 0; g < N; g++) begin cpu_we[g] = 1'b0; cpu_addr[g] = 16'h0020; end
    xfer(1'b1, 1'b1, 16'h0020, 16'h1234, 1'b1);
    xfer(1'b0, 1'b0, 16'h0020, 16'h1234, 1'b0);

    // Reset in the strobe cycle of a write: strobe must drop immediately.
    for (int g = 0; g < N; g++) begin
      cpu_req[g] = 1'b1; cpu_we[g] = 1'b1; cpu_addr[g] = 16'h0030; cpu_wdata[g] = 16'h5555;
    end
    step();
    for (int g = 0; g < N; g++) chk($sformatf("issue_en inst%0d", g), 70'(mem_en[g]), 70'(1));
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < N; g++) chk($sformatf("rst_issue_en inst%0d", g), 70'(mem_en[g]), 70'(0));
    check_all();
    for (int g = 0; g < N; g++) cpu_req[g] = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    xfer(1'b0, 1'b0, 16'h0030, 16'h0000, 1'b0);

    // Continuous contention.
    for (int g = 0; g < N; g++) begin
      cpu_req[g] = 1'b1; ext_req[g] = 1'b1; cpu_we[g] = 1'b0; ext_we[g] = 1'b0;
      nc[g] = 0; ne[g] = 0;
    end
    repeat (24) begin
      step();
      for (int g = 0; g < N; g++) begin nc[g] += int'(cpu_ack[g]); ne[g] += int'(ext_ack[g]); end
    end
    chk("rr_cpu_acks", 70'(nc[0]), 70'(3));
    chk("rr_ext_acks", 70'(ne[0]), 70'(3));
    chk("fixed_ext_starved", 70'(ne[1]), 70'(0));
    for (int g = 0; g < N; g++) begin cpu_req[g] = 1'b0; ext_req[g] = 1'b0; end
    repeat (8) step();

    // Random traffic against the model, with occasional resets.
    repeat (1500) begin
      step();
      rst_n = ($urandom_range(0, 299) != 0);
      for (int g = 0; g < N; g++) begin
        cpu_req[g]   = ($urandom_range(0, 3) != 0);
        ext_req[g]   = ($urandom_range(0, 2) == 0);
        ext_hold[g]  = ($urandom_range(0, 4) == 0);
        cpu_we[g]    = $urandom_range(0, 1) == 1;
        ext_we[g]    = $urandom_range(0, 1) == 1;
        cpu_addr[g]  = 16'($urandom);
        ext_addr[g]  = 16'($urandom);
        cpu_wdata[g] = 16'($urandom);
        ext_wdata[g] = 16'($urandom);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
